// File: rtl/vga_sprite_sequencer_pkg.sv
// vga_sprite_sequencer_pkg: screen layout, sprite codes and region encoding for the sprite sequencer
package vga_sprite_sequencer_pkg;
  localparam logic [9:0] DIG_W     = 10'd20;
  localparam logic [9:0] DIG_H     = 10'd30;
  localparam logic [9:0] ALM_SZ    = 10'd25;
  localparam logic [9:0] ALM_X0    = 10'd275;
  localparam logic [9:0] ALM_Y0    = 10'd275;
  localparam logic [9:0] SNAP_LINE = 10'd480;
  localparam logic [9:0] TIMEOUT   = 10'd1023;
  localparam logic [4:0] BLINK_FR  = 5'd30;
  localparam logic [2:0][9:0] BAND_Y0 = {10'd246, 10'd185, 10'd122};
  localparam logic [5:0][9:0] COL_X0  = {10'd245, 10'd225, 10'd200, 10'd180, 10'd155, 10'd135};
  localparam logic [3:0] SPR_ALARM = 4'hA;
  localparam logic [3:0] SPR_NONE  = 4'hF;
  typedef enum logic [1:0] {RG_NONE, RG_DIGIT, RG_ALARM} region_e;
  typedef struct packed {
    region_e    kind;
    logic [1:0] band;
    logic [2:0] col;
  } region_t;
  function automatic logic in_span(logic [9:0] p, logic [9:0] lo, logic [9:0] len);
    return p >= lo && p < lo + len;
  endfunction
  // Byte 0 (DIA) sits in the top byte; even columns show the tens nibble.
  function automatic logic [3:0] digit_nib(logic [71:0] s, logic [1:0] b, logic [2:0] c);
    logic [3:0]  i;
    logic [6:0]  sh;
    logic [71:0] t;
    i  = {2'b0, b} * 4'd3 + {2'b0, c[2:1]};
    sh = {3'b0, i} << 3;
    t  = s << sh;
    return c[0] ? t[67:64] : t[71:68];
  endfunction
endpackage

// File: rtl/vga_sprite_sequencer_if.sv
// vga_sprite_sequencer_if: sync-side inputs, RTC snapshot handshake and sprite ROM outputs
interface vga_sprite_sequencer_if;
  logic [9:0]  addrh;
  logic [9:0]  addrv;
  logic        video_on;
  logic        alarm;
  logic        snap_ack;
  logic [71:0] snap_data;
  logic        snap_req;
  logic        snap_miss;
  logic [3:0]  spr_sel;
  logic [9:0]  spr_addr;
  modport master (output addrh, addrv, video_on, alarm, snap_ack, snap_data,
                  input snap_req, snap_miss, spr_sel, spr_addr);
  modport slave  (input addrh, addrv, video_on, alarm, snap_ack, snap_data,
                  output snap_req, snap_miss, spr_sel, spr_addr);
endinterface

// File: rtl/vga_sprite_sequencer_rtc_snapshot_hs.sv
// vga_sprite_sequencer_rtc_snapshot_hs: once-per-frame RTC snapshot via req/ack with timeout
module vga_sprite_sequencer_rtc_snapshot_hs
  import vga_sprite_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        trig_i,
  input  logic        ack_i,
  input  logic [71:0] data_i,
  output logic        req_o,
  output logic        miss_o,
  output logic [71:0] snap_o
);
  typedef enum logic {IDLE, REQ} state_e;
  state_e      state_q;
  logic [9:0]  tmr_q;
  logic        req_q, miss_q;
  logic [71:0] snap_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      req_q   <= 1'b0;
      miss_q  <= 1'b0;
      snap_q  <= '1;
    end else begin
      miss_q <= 1'b0;
      if (state_q == IDLE) begin
        if (trig_i) begin
          state_q <= REQ;
          req_q   <= 1'b1;
          tmr_q   <= '0;
        end
      end else if (ack_i) begin
        snap_q  <= data_i;
        req_q   <= 1'b0;
        state_q <= IDLE;
      end else if (tmr_q == TIMEOUT - 10'd1) begin
        req_q   <= 1'b0;
        miss_q  <= 1'b1;
        state_q <= IDLE;
      end else begin
        tmr_q <= tmr_q + 10'd1;
      end
    end
  end
  assign req_o  = req_q;
  assign miss_o = miss_q;
  assign snap_o = snap_q;
endmodule

// File: rtl/vga_sprite_sequencer.sv
// vga_sprite_sequencer: per-pixel sprite select and column-major ROM address, 2-stage pipeline
module vga_sprite_sequencer
  import vga_sprite_sequencer_pkg::*;
(
  input logic clk,
  input logic rst,
  vga_sprite_sequencer_if.slave bus
);
  logic        trig;
  logic [71:0] snap;
  logic [4:0]  cnt_q, cnt_d;
  logic        hide_q, hide_d;
  region_t     rg_q, rg_d;
  logic [4:0]  dx_q, dx_d, dy_q, dy_d;
  logic [3:0]  nib, sel_q, sel_d;
  logic [9:0]  addr_q, addr_d;
  logic        bhit, chit;
  assign trig = bus.addrv == SNAP_LINE && bus.addrh == 10'd0;
  vga_sprite_sequencer_rtc_snapshot_hs u_snap (
    .clk    (clk),
    .rst    (rst),
    .trig_i (trig),
    .ack_i  (bus.snap_ack),
    .data_i (bus.snap_data),
    .req_o  (bus.snap_req),
    .miss_o (bus.snap_miss),
    .snap_o (snap)
  );
  always_comb begin
    cnt_d  = cnt_q;
    hide_d = hide_q;
    if (!bus.alarm) begin
      cnt_d  = '0;
      hide_d = 1'b0;
    end else if (trig) begin
      cnt_d  = cnt_q == BLINK_FR - 5'd1 ? 5'd0 : cnt_q + 5'd1;
      hide_d = cnt_q == BLINK_FR - 5'd1 ? ~hide_q : hide_q;
    end
  end
  always_comb begin
    rg_d = '0;
    dx_d = '0;
    dy_d = '0;
    bhit = 1'b0;
    chit = 1'b0;
    for (int b = 0; b < 3; b++)
      if (in_span(bus.addrv, BAND_Y0[2'(b)], DIG_H)) begin
        bhit      = 1'b1;
        rg_d.band = 2'(b);
        dy_d      = 5'(bus.addrv - BAND_Y0[2'(b)]);
      end
    for (int c = 0; c < 6; c++)
      if (in_span(bus.addrh, COL_X0[3'(c)], DIG_W)) begin
        chit     = 1'b1;
        rg_d.col = 3'(c);
        dx_d     = 5'(bus.addrh - COL_X0[3'(c)]);
      end
    if (bhit && chit) rg_d.kind = RG_DIGIT;
    // Alarm wins over digits; a hidden icon still claims its area as background.
    if (in_span(bus.addrh, ALM_X0, ALM_SZ) && in_span(bus.addrv, ALM_Y0, ALM_SZ)) begin
      rg_d.kind = bus.alarm && !hide_q ? RG_ALARM : RG_NONE;
      dx_d      = 5'(bus.addrh - ALM_X0);
      dy_d      = 5'(bus.addrv - ALM_Y0);
    end
    if (!bus.video_on) rg_d.kind = RG_NONE;
  end
  always_comb begin
    nib    = digit_nib(snap, rg_q.band, rg_q.col);
    sel_d  = rg_q.kind == RG_ALARM ? SPR_ALARM :
             (rg_q.kind == RG_DIGIT && nib <= 4'd9) ? nib : SPR_NONE;
    addr_d = sel_d == SPR_NONE ? 10'd0 :
             {5'd0, dy_q} + {5'd0, dx_q} * (rg_q.kind == RG_ALARM ? ALM_SZ : DIG_H);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      hide_q <= 1'b0;
      rg_q   <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      sel_q  <= SPR_NONE;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hide_q <= hide_d;
      rg_q   <= rg_d;
      dx_q   <= dx_d;
      dy_q   <= dy_d;
      sel_q  <= sel_d;
      addr_q <= addr_d;
    end
  end
  assign bus.spr_sel  = sel_q;
  assign bus.spr_addr = addr_q;
endmodule

// File: tb/tb_vga_sprite_sequencer.sv
// tb_vga_sprite_sequencer: directed checks of decode pipeline, snapshot handshake, blink and reset
module tb_vga_sprite_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  localparam logic [71:0] D1 = 72'h27_12_24_13_45_59_00_07_30;
  localparam logic [71:0] D2 = 72'h3A_12_24_13_45_59_00_07_30;
  always #5 clk = ~clk;
  vga_sprite_sequencer_if bus ();
  vga_sprite_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic [3:0] es,
                     input logic [9:0] ea, input string tag);
    bus.addrh = h;
    bus.addrv = v;
    cyc();
    bus.addrh = 10'd0;
    bus.addrv = 10'd0;
    cyc();
    chk({tag, "_sel"}, 72'(bus.spr_sel), 72'(es));
    chk({tag, "_addr"}, 72'(bus.spr_addr), 72'(ea));
  endtask
  task automatic frame();
    bus.addrh = 10'd0;
    bus.addrv = 10'd480;
    cyc();
    bus.addrv = 10'd0;
  endtask
  task automatic hs(input logic [71:0] d, input int lag);
    frame();
    chk("hs_req", 72'(bus.snap_req), 72'd1);
    repeat (lag) cyc();
    bus.snap_data = d;
    bus.snap_ack  = 1'b1;
    cyc();
    bus.snap_ack = 1'b0;
    chk("hs_drop", 72'(bus.snap_req), 72'd0);
  endtask
  initial begin
    bus.addrh = 10'd0;
    bus.addrv = 10'd0;
    bus.video_on = 1'b1;
    bus.alarm = 1'b0;
    bus.snap_ack = 1'b0;
    bus.snap_data = '0;
    repeat (3) cyc();
    chk("rst_req", 72'(bus.snap_req), 72'd0);
    chk("rst_miss", 72'(bus.snap_miss), 72'd0);
    chk("rst_sel", 72'(bus.spr_sel), 72'hF);
    chk("rst_addr", 72'(bus.spr_addr), 72'd0);
    rst = 1'b0;
    cyc();
    pix(10'd140, 10'd130, 4'hF, 10'd0, "blank_digit");
    pix(10'd280, 10'd290, 4'hF, 10'd0, "alarm_off");
    frame();
    chk("req_rise", 72'(bus.snap_req), 72'd1);
    repeat (1022) cyc();
    chk("req_hold", 72'(bus.snap_req), 72'd1);
    chk("miss_early", 72'(bus.snap_miss), 72'd0);
    cyc();
    chk("req_timeout", 72'(bus.snap_req), 72'd0);
    chk("miss_pulse", 72'(bus.snap_miss), 72'd1);
    cyc();
    chk("miss_end", 72'(bus.snap_miss), 72'd0);
    pix(10'd140, 10'd130, 4'hF, 10'd0, "kept_after_miss");
    hs(D1, 3);
    pix(10'd140, 10'd130, 4'd2, 10'd158, "dia_hi");
    pix(10'd155, 10'd122, 4'd7, 10'd0, "dia_lo");
    pix(10'd264, 10'd214, 4'd9, 10'd599, "seg_last");
    pix(10'd265, 10'd214, 4'hF, 10'd0, "seg_past");
    pix(10'd245, 10'd246, 4'd0, 10'd0, "segt_lo");
    pix(10'd134, 10'd130, 4'hF, 10'd0, "left_edge");
    pix(10'd140, 10'd152, 4'hF, 10'd0, "below_band");
    bus.video_on = 1'b0;
    pix(10'd140, 10'd130, 4'hF, 10'd0, "video_off");
    bus.video_on = 1'b1;
    bus.snap_data = D2;
    repeat (5) cyc();
    pix(10'd140, 10'd130, 4'd2, 10'd158, "no_ack_hold");
    bus.snap_ack = 1'b1;
    cyc();
    bus.snap_ack = 1'b0;
    pix(10'd140, 10'd130, 4'd2, 10'd158, "idle_ack");
    hs(D2, 3);
    pix(10'd140, 10'd130, 4'd3, 10'd158, "new_dia_hi");
    pix(10'd155, 10'd130, 4'hF, 10'd0, "nib_gt9");
    bus.alarm = 1'b1;
    pix(10'd280, 10'd290, 4'hA, 10'd140, "alarm_on");
    pix(10'd299, 10'd299, 4'hA, 10'd624, "alarm_corner");
    repeat (29) frame();
    pix(10'd280, 10'd290, 4'hA, 10'd140, "blink_29");
    frame();
    pix(10'd280, 10'd290, 4'hF, 10'd0, "blink_off");
    repeat (30) frame();
    pix(10'd280, 10'd290, 4'hA, 10'd140, "blink_on");
    bus.alarm = 1'b0;
    pix(10'd280, 10'd290, 4'hF, 10'd0, "alarm_low");
    bus.alarm = 1'b1;
    pix(10'd280, 10'd290, 4'hA, 10'd140, "alarm_rise");
    bus.alarm = 1'b0;
    repeat (1100) cyc();
    frame();
    chk("pre_rst_req", 72'(bus.snap_req), 72'd1);
    bus.addrh = 10'd140;
    bus.addrv = 10'd130;
    cyc();
    cyc();
    chk("pre_rst_sel", 72'(bus.spr_sel), 72'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_req", 72'(bus.snap_req), 72'd0);
    chk("async_sel", 72'(bus.spr_sel), 72'hF);
    chk("async_addr", 72'(bus.spr_addr), 72'd0);
    cyc();
    rst = 1'b0;
    pix(10'd140, 10'd130, 4'hF, 10'd0, "snap_reset");
    hs(D1, 1);
    pix(10'd140, 10'd130, 4'd2, 10'd158, "post_rst_hs");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
